// File: rtl/accel_seq_unit.sv
// accel_seq_unit: byte-addressed TinyQV peripheral with four operand
// registers, a start/busy/done ALU sequencer, a shift-add multiplier,
// status flags with W1C done/err, optional writeback and an op counter.
module accel_seq_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned SHW = $clog2(WIDTH) + 1;
  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned RW  = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [4];
  logic [7:0]       ctrl;
  logic [2:0]       ctrl2;
  logic             busy, done, err, zf, cf, vf;
  logic [RW-1:0]    res;
  logic [7:0]       opcnt;

  // operand snapshot taken at start
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa, opb;

  // shift-add multiplier datapath
  logic [RW-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    mcnt;

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [RW-1:0]    mul_next;
  logic             mul_last;
  logic             fin, fin_z, fin_c, fin_v;
  logic [RW-1:0]    fin_res;
  logic             op_legal;
  logic [15:0]      rd_reg;
  logic [31:0]      res_ext;
  logic             unused_in;

  assign unused_in = &{1'b0, ui_in};
  assign uo_out    = {5'b0, done, busy, 1'b0};

  // single-cycle ALU on the snapshotted operands
  always_comb begin
    sum     = {1'b0, opa} + {1'b0, opb};
    diff    = {1'b0, opa} - {1'b0, opb};
    amt     = opb[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      4'd0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      4'd2: alu_res = opa & opb;
      4'd3: alu_res = opa | opb;
      4'd4: alu_res = opa ^ opb;
      4'd5: alu_res = (amt >= SHW'(WIDTH)) ? '0 : (opa << amt);
      4'd6: alu_res = (amt >= SHW'(WIDTH)) ? '0 : (opa >> amt);
      4'd8: alu_res = opa;
      default: alu_res = '0;
    endcase
  end

  // multiplier step and completion selection
  always_comb begin
    mul_next = acc + (mplier[0] ? mcand : '0);
    mul_last = (mcnt == CW'(WIDTH - 1));
    fin      = (state == S_EXEC) || ((state == S_MUL) && mul_last);
    fin_res  = (state == S_MUL) ? mul_next : {{WIDTH{1'b0}}, alu_res};
    fin_c    = (state == S_MUL) ? 1'b0 : alu_c;
    fin_v    = (state == S_MUL) ? 1'b0 : alu_v;
    fin_z    = (fin_res[WIDTH-1:0] == '0);
    op_legal = (data_in[3:0] <= 4'd8) && ((data_in[3:0] != 4'd7) || MUL_EN);
  end

  // register file, host writes and sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      for (int unsigned k = 0; k < 4; k++) regs[k] <= '0;
      ctrl   <= 8'h40;
      ctrl2  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      vf     <= 1'b0;
      res    <= '0;
      opcnt  <= '0;
      op_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mcnt   <= '0;
    end else begin
      if (data_write) begin
        if (address == 4'hA) begin
          if (data_in[1]) done <= 1'b0;
          if (data_in[2]) err  <= 1'b0;
        end else if (busy) begin
          if ((address <= 4'h9) || (address == 4'hF)) err <= 1'b1;
        end else begin
          case (address)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              // byte lanes beyond WIDTH never match, so odd bytes drop at WIDTH=8
              for (int unsigned i = 0; i < WIDTH; i++)
                if ((i / 8) == 32'(address[0])) regs[address[2:1]][i] <= data_in[i % 8];
            end
            4'h8: begin
              ctrl <= data_in;
              if (op_legal) begin
                opa    <= regs[data_in[5:4]];
                opb    <= regs[data_in[7:6]];
                op_q   <= data_in[3:0];
                acc    <= '0;
                mcand  <= RW'(regs[data_in[5:4]]);
                mplier <= regs[data_in[7:6]];
                mcnt   <= '0;
                busy   <= 1'b1;
                done   <= 1'b0;
                state  <= (data_in[3:0] == 4'd7) ? S_MUL : S_EXEC;
              end else begin
                err <= 1'b1;
              end
            end
            4'h9: ctrl2 <= data_in[2:0];
            4'hF: opcnt <= '0;
            default: ;
          endcase
        end
      end

      if ((state == S_MUL) && !mul_last) begin
        acc    <= mul_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        mcnt   <= mcnt + CW'(1);
      end

      // completion overrides a same-edge W1C of done
      if (fin) begin
        res   <= fin_res;
        zf    <= fin_z;
        cf    <= fin_c;
        vf    <= fin_v;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= S_IDLE;
        opcnt <= opcnt + 8'd1;
        if (ctrl2[0]) regs[ctrl2[2:1]] <= fin_res[WIDTH-1:0];
      end
    end
  end

  // combinational read mux
  always_comb begin
    rd_reg  = 16'(regs[address[2:1]]);
    res_ext = 32'(res);
    case (address)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
        data_out = address[0] ? rd_reg[15:8] : rd_reg[7:0];
      4'h8: data_out = ctrl;
      4'h9: data_out = {5'b0, ctrl2};
      4'hA: data_out = {2'b0, vf, cf, zf, err, done, busy};
      4'hB: data_out = res_ext[7:0];
      4'hC: data_out = res_ext[15:8];
      4'hD: data_out = res_ext[23:16];
      4'hE: data_out = res_ext[31:24];
      default: data_out = opcnt;
    endcase
  end

endmodule

// File: tb/tb_accel_seq_unit.sv
// Directed testbench for accel_seq_unit: 8-bit, 16-bit and MUL-disabled builds.
module tb_accel_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [3:0] address = 4'h0;
  logic [7:0] data_in = 8'h00;
  logic       we8 = 1'b0, we16 = 1'b0, wen = 1'b0;
  logic [7:0] uo8, uo16, uon, do8, do16, don;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accel_seq_unit #(.WIDTH(8), .MUL_EN(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo8),
    .address(address), .data_write(we8), .data_in(data_in), .data_out(do8));

  accel_seq_unit #(.WIDTH(16), .MUL_EN(1'b1)) u16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16),
    .address(address), .data_write(we16), .data_in(data_in), .data_out(do16));

  accel_seq_unit #(.WIDTH(8), .MUL_EN(1'b0)) un (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uon),
    .address(address), .data_write(wen), .data_in(data_in), .data_out(don));

  function automatic logic [7:0] uo_of(input int d);
    return (d == 0) ? uo8 : (d == 1) ? uo16 : uon;
  endfunction

  task automatic wr(input int d, input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    address = a;
    data_in = v;
    if (d == 0) we8 = 1'b1; else if (d == 1) we16 = 1'b1; else wen = 1'b1;
    @(posedge clk);
    #1;
    we8 = 1'b0; we16 = 1'b0; wen = 1'b0;
  endtask

  task automatic rd(input int d, input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = (d == 0) ? do8 : (d == 1) ? do16 : don;
  endtask

  task automatic wait_idle(input int d, output int n);
    logic [7:0] u;
    n = 0;
    u = uo_of(d);
    while (u[1] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      u = uo_of(d);
    end
  endtask

  task automatic test_reset();
    logic [3:0] a [5];
    logic [7:0] v;
    a = '{4'h8, 4'hA, 4'hF, 4'hB, 4'h0};
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 5; i++) begin
        rd(d, a[i], v);
        checks++;
        if (v !== ((i == 0) ? 8'h40 : 8'h00)) begin
          errors++;
          $display("FAIL reset_reg inst%0d addr %h got %h exp %h", d, a[i], v, (i == 0) ? 8'h40 : 8'h00);
        end
      end
      checks++;
      if (uo_of(d) !== 8'h00) begin
        errors++;
        $display("FAIL reset_uo inst%0d got %h exp 00", d, uo_of(d));
      end
    end
  endtask

  task automatic test_add();
    logic [7:0] v;
    int n;
    wr(0, 4'h0, 8'hF0);
    wr(0, 4'h1, 8'h55);
    wr(0, 4'h2, 8'h20);
    wr(0, 4'h8, 8'h40);
    checks++;
    if (uo8 !== 8'h02) begin errors++; $display("FAIL add_busy got %h exp 02", uo8); end
    wait_idle(0, n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL add_latency got %0d exp 1", n); end
    checks++;
    if (uo8 !== 8'h04) begin errors++; $display("FAIL add_uo_done got %h exp 04", uo8); end
    rd(0, 4'h1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL odd_addr got %h exp 00", v); end
    rd(0, 4'hB, v); checks++;
    if (v !== 8'h10) begin errors++; $display("FAIL add_res0 got %h exp 10", v); end
    rd(0, 4'hC, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL add_res1 got %h exp 00", v); end
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h12) begin errors++; $display("FAIL add_status got %h exp 12", v); end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL add_opcnt got %h exp 01", v); end
  endtask

  task automatic test_sub_wb();
    logic [7:0] v;
    int n;
    wr(0, 4'h0, 8'h80);
    wr(0, 4'h2, 8'h01);
    wr(0, 4'h9, 8'h05);
    wr(0, 4'h8, 8'h41);
    wait_idle(0, n);
    rd(0, 4'hB, v); checks++;
    if (v !== 8'h7F) begin errors++; $display("FAIL sub_res0 got %h exp 7f", v); end
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h22) begin errors++; $display("FAIL sub_status got %h exp 22", v); end
    rd(0, 4'h4, v); checks++;
    if (v !== 8'h7F) begin errors++; $display("FAIL sub_writeback got %h exp 7f", v); end
    rd(0, 4'h9, v); checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL ctrl2_read got %h exp 05", v); end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL sub_opcnt got %h exp 02", v); end
    wr(0, 4'h9, 8'h00);
  endtask

  task automatic test_mul8();
    logic [7:0] v;
    int n;
    wr(0, 4'h0, 8'hFF);
    wr(0, 4'h2, 8'hFF);
    wr(0, 4'h8, 8'h47);
    wr(0, 4'h0, 8'h00);
    wait_idle(0, n);
    checks++;
    if (n + 1 != 8) begin errors++; $display("FAIL mul8_busy_cycles got %0d exp 8", n + 1); end
    rd(0, 4'hB, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL mul8_res0 got %h exp 01", v); end
    rd(0, 4'hC, v); checks++;
    if (v !== 8'hFE) begin errors++; $display("FAIL mul8_res1 got %h exp fe", v); end
    rd(0, 4'hD, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL mul8_res2 got %h exp 00", v); end
    rd(0, 4'h0, v); checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL busy_write_ignored got %h exp ff", v); end
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h06) begin errors++; $display("FAIL mul8_status got %h exp 06", v); end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL mul8_opcnt got %h exp 03", v); end
    wr(0, 4'hA, 8'h06);
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL w1c_clear got %h exp 00", v); end
  endtask

  task automatic test_illegal();
    logic [7:0] v;
    wr(0, 4'h8, 8'h4C);
    checks++;
    if (uo8 !== 8'h00) begin errors++; $display("FAIL illegal_uo got %h exp 00", uo8); end
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL illegal_status got %h exp 04", v); end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL illegal_opcnt got %h exp 03", v); end
    rd(0, 4'h8, v); checks++;
    if (v !== 8'h4C) begin errors++; $display("FAIL illegal_ctrl got %h exp 4c", v); end
    rd(0, 4'hB, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL illegal_res0 got %h exp 01", v); end
    wr(0, 4'hA, 8'h04);
  endtask

  task automatic test_w1c_race();
    logic [7:0] v;
    wr(0, 4'h8, 8'h40);
    wr(0, 4'hA, 8'h02);
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h12) begin errors++; $display("FAIL w1c_race_status got %h exp 12", v); end
    rd(0, 4'hB, v); checks++;
    if (v !== 8'hFE) begin errors++; $display("FAIL w1c_race_res0 got %h exp fe", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    int n;
    wr(0, 4'h8, 8'h44);
    checks++;
    if (uo8 !== 8'h02) begin errors++; $display("FAIL b2b_accept got %h exp 02", uo8); end
    wait_idle(0, n);
    rd(0, 4'hA, v); checks++;
    if (v !== 8'h0A) begin errors++; $display("FAIL b2b_status got %h exp 0a", v); end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL b2b_opcnt got %h exp 05", v); end
  endtask

  task automatic test_ops();
    logic [7:0] ctl [8];
    logic [7:0] er [8];
    logic [7:0] es [8];
    logic [7:0] v;
    int n;
    ctl = '{8'h42, 8'h43, 8'h44, 8'h46, 8'h45, 8'h48, 8'h41, 8'h11};
    er  = '{8'h0C, 8'h3F, 8'h33, 8'h00, 8'h00, 8'h3C, 8'h2D, 8'hD3};
    es  = '{8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h02, 8'h02, 8'h12};
    wr(0, 4'h0, 8'h3C);
    wr(0, 4'h2, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      wr(0, 4'h8, ctl[i]);
      wait_idle(0, n);
      rd(0, 4'hB, v); checks++;
      if (v !== er[i]) begin errors++; $display("FAIL ops_res ctrl %h got %h exp %h", ctl[i], v, er[i]); end
      rd(0, 4'hA, v); checks++;
      if (v !== es[i]) begin errors++; $display("FAIL ops_status ctrl %h got %h exp %h", ctl[i], v, es[i]); end
    end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h0D) begin errors++; $display("FAIL ops_opcnt got %h exp 0d", v); end
    wr(0, 4'hF, 8'h55);
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL opcnt_clear got %h exp 00", v); end
  endtask

  task automatic test_wide16();
    logic [7:0] v;
    logic [7:0] em [4];
    int n;
    em = '{8'h01, 8'h00, 8'hFE, 8'hFF};
    wr(1, 4'h0, 8'h34);
    wr(1, 4'h1, 8'h12);
    wr(1, 4'h2, 8'h04);
    wr(1, 4'h3, 8'h00);
    wr(1, 4'h8, 8'h45);
    wait_idle(1, n);
    rd(1, 4'hB, v); checks++;
    if (v !== 8'h40) begin errors++; $display("FAIL w16_shl_res0 got %h exp 40", v); end
    rd(1, 4'hC, v); checks++;
    if (v !== 8'h23) begin errors++; $display("FAIL w16_shl_res1 got %h exp 23", v); end
    rd(1, 4'hA, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL w16_shl_status got %h exp 02", v); end
    rd(1, 4'h1, v); checks++;
    if (v !== 8'h12) begin errors++; $display("FAIL w16_r0_hi got %h exp 12", v); end
    wr(1, 4'h2, 8'h10);
    wr(1, 4'h8, 8'h45);
    wait_idle(1, n);
    rd(1, 4'hC, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL w16_shl16_res1 got %h exp 00", v); end
    rd(1, 4'hA, v); checks++;
    if (v !== 8'h0A) begin errors++; $display("FAIL w16_shl16_status got %h exp 0a", v); end
    for (int i = 0; i < 4; i++) wr(1, 4'(i), 8'hFF);
    wr(1, 4'h8, 8'h47);
    wait_idle(1, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL w16_mul_cycles got %0d exp 16", n); end
    for (int i = 0; i < 4; i++) begin
      rd(1, 4'(11 + i), v); checks++;
      if (v !== em[i]) begin errors++; $display("FAIL w16_mul_res byte%0d got %h exp %h", i, v, em[i]); end
    end
    rd(1, 4'hA, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL w16_mul_status got %h exp 02", v); end
    wr(1, 4'h2, 8'h01);
    wr(1, 4'h3, 8'h00);
    wr(1, 4'h8, 8'h40);
    wait_idle(1, n);
    rd(1, 4'hC, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL w16_add_res1 got %h exp 00", v); end
    rd(1, 4'hA, v); checks++;
    if (v !== 8'h1A) begin errors++; $display("FAIL w16_add_status got %h exp 1a", v); end
    rd(1, 4'hF, v); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL w16_opcnt got %h exp 04", v); end
  endtask

  task automatic test_mul_disabled();
    logic [7:0] v;
    int n;
    wr(2, 4'h0, 8'h03);
    wr(2, 4'h2, 8'h05);
    wr(2, 4'h8, 8'h47);
    checks++;
    if (uon !== 8'h00) begin errors++; $display("FAIL nomul_uo got %h exp 00", uon); end
    rd(2, 4'hA, v); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL nomul_status got %h exp 04", v); end
    rd(2, 4'hF, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL nomul_opcnt got %h exp 00", v); end
    wr(2, 4'h8, 8'h40);
    wait_idle(2, n);
    rd(2, 4'hB, v); checks++;
    if (v !== 8'h08) begin errors++; $display("FAIL nomul_add_res0 got %h exp 08", v); end
    rd(2, 4'hA, v); checks++;
    if (v !== 8'h06) begin errors++; $display("FAIL nomul_add_status got %h exp 06", v); end
  endtask

  task automatic test_reset_mid_mul();
    logic [3:0] a [6];
    logic [7:0] e [6];
    logic [7:0] v;
    a = '{4'h8, 4'h9, 4'hA, 4'hF, 4'hB, 4'h0};
    e = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    wr(0, 4'h8, 8'h47);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (uo8 !== 8'h00) begin errors++; $display("FAIL midreset_uo got %h exp 00", uo8); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      rd(0, a[i], v); checks++;
      if (v !== e[i]) begin errors++; $display("FAIL midreset addr %h got %h exp %h", a[i], v, e[i]); end
    end
    checks++;
    if (uo8 !== 8'h00) begin errors++; $display("FAIL midreset_uo_later got %h exp 00", uo8); end
  endtask

  task automatic test_opcnt_wrap();
    logic [7:0] v;
    int n;
    for (int i = 0; i < 255; i++) begin
      wr(0, 4'h8, 8'h40);
      wait_idle(0, n);
    end
    rd(0, 4'hF, v); checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL opcnt_255 got %h exp ff", v); end
    wr(0, 4'h8, 8'h40);
    wait_idle(0, n);
    rd(0, 4'hF, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL opcnt_wrap got %h exp 00", v); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_sub_wb();
    test_mul8();
    test_illegal();
    test_w1c_race();
    test_back_to_back();
    test_ops();
    test_wide16();
    test_mul_disabled();
    test_reset_mid_mul();
    test_opcnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
